// File: rtl/javk_fetch.sv
// Instruction-fetch front end for the JAVK CPU: single-outstanding memory
// fetch into a DEPTH-entry prefetch queue. Define JAVK_FETCH_PERF_EN for perf counters.
module javk_fetch #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 8,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          bus_grant,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  output logic [AW-1:0] fetch_pc
`ifdef JAVK_FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_flushed
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d, cnt_next;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d, mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;
  logic          resp_keep, push, pop, issue;

  assign instr_valid = (count_q != '0);
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign fetch_pc    = fetch_pc_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_comb begin
    resp_keep = (state_q == WAIT) && mem_valid;
    pop       = instr_valid && instr_ready && !redirect;
    push      = resp_keep && !redirect;
    cnt_next  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    // Issue uses the post-push/pop occupancy so a full queue can refill in the pop cycle
    issue     = !redirect && bus_grant && ((state_q == IDLE) || resp_keep) &&
                (cnt_next < FULL_CNT);

    state_d    = state_q;
    fetch_pc_d = push ? fetch_pc_q + AW'(1) : fetch_pc_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1)   : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1)   : wr_ptr_q;
    count_d    = cnt_next;

    case (state_q)
      WAIT:    if (mem_valid) state_d = IDLE;
               else if (redirect) state_d = DISCARD;
      DISCARD: if (mem_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) state_d = WAIT;

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
    end

    // Back-to-back issue must fetch the byte after the one just pushed
    mem_req_d  = issue;
    mem_addr_d = issue ? fetch_pc_d : mem_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
    end
  end

`ifdef JAVK_FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (push && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 16'd1;
    if (redirect && (perf_flushed_q != '1)) perf_flushed_d = perf_flushed_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_javk_fetch.sv
// Self-checking bench for javk_fetch: memory responder plus a queue-level
// scoreboard of the fetch stream; scenario tasks run in sequence.
module tb_javk_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, redirect, bus_grant, mem_valid, instr_ready;
  logic [15:0] redirect_pc;
  logic [7:0]  mem_rdata;
  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr_pc, fetch_pc;
  logic [7:0]  instr_data;
`ifdef JAVK_FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  javk_fetch #(.AW(16), .DW(8), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_grant(bus_grant), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .fetch_pc(fetch_pc)
`ifdef JAVK_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: addresses of bytes the queue should hold, in order
  logic [15:0] q[$];
  logic [15:0] consumed[$];
  logic [7:0]  cdata[$];
  logic [15:0] reqs[$];
  int          req_cyc[$];

  logic        pend = 1'b0, live = 1'b0, orphan = 1'b0, exp_req = 1'b0;
  logic [15:0] paddr, exp_addr, held_addr;
  int          pwait, cyc = 0;
  int          lat_min = 1, lat_max = 1, spur_pct = 0;
  logic        slow_en = 1'b0;
  logic [15:0] slow_addr;
  int          slow_lat;
  logic        redir_on_resp = 1'b0, auto_fired = 1'b0, redir_done = 1'b0;
  logic [15:0] redir_target;
  int          redir_cyc, redir_idx;
  int unsigned m_fetched = 0, m_flushed = 0;

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ {1'b0, a[15:9]};
  endfunction

  task automatic cycle();
    logic        resp, keep, do_pop, can_issue;
    logic [15:0] exp_fpc;
    mem_valid = 1'b0;
    mem_rdata = 8'($urandom);

    checks++;
    if (mem_req !== exp_req) begin
      errors++;
      $display("FAIL mem_req: got %b expected %b (cycle %0d)", mem_req, exp_req, cyc);
    end
    if (mem_req === 1'b1) begin
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL mem_addr: got %h expected %h (cycle %0d)", mem_addr, exp_addr, cyc);
      end
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL single_outstanding: got 2 requests expected 1 (cycle %0d)", cyc);
      end
      reqs.push_back(mem_addr);
      req_cyc.push_back(cyc);
      pend = 1'b1; live = 1'b1; paddr = exp_addr; held_addr = exp_addr;
      exp_addr = exp_addr + 16'd1;
      pwait = (slow_en && paddr == slow_addr) ? slow_lat : $urandom_range(lat_max, lat_min);
    end else begin
      checks++;
      if (mem_addr !== held_addr) begin
        errors++;
        $display("FAIL mem_addr_hold: got %h expected %h (cycle %0d)", mem_addr, held_addr, cyc);
      end
    end

    exp_fpc = (pend && live) ? exp_addr - 16'd1 : exp_addr;
    checks++;
    if (fetch_pc !== exp_fpc) begin
      errors++;
      $display("FAIL fetch_pc: got %h expected %h (cycle %0d)", fetch_pc, exp_fpc, cyc);
    end
    checks++;
    if (instr_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL instr_valid: got %b expected %b (cycle %0d)", instr_valid, q.size() != 0, cyc);
    end
    if (q.size() != 0) begin
      checks++;
      if (instr_pc !== q[0]) begin
        errors++;
        $display("FAIL instr_pc: got %h expected %h (cycle %0d)", instr_pc, q[0], cyc);
      end
      checks++;
      if (instr_data !== f(q[0])) begin
        errors++;
        $display("FAIL instr_data: got %h expected %h (cycle %0d)", instr_data, f(q[0]), cyc);
      end
    end
`ifdef JAVK_FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 16'(m_fetched) || perf_flushed !== 16'(m_flushed)) begin
      errors++;
      $display("FAIL perf: got %0d/%0d expected %0d/%0d (cycle %0d)",
               perf_fetched, perf_flushed, m_fetched, m_flushed, cyc);
    end
`endif

    // Memory responder
    if (orphan) begin
      mem_valid = 1'b1;
      orphan = 1'b0;
    end else if (pend) begin
      if (pwait == 0) begin
        mem_valid = 1'b1;
        mem_rdata = f(paddr);
      end else begin
        pwait--;
      end
    end else if (int'($urandom_range(99)) < spur_pct) begin
      mem_valid = 1'b1;
    end
    if (redir_on_resp && mem_valid && pend) begin
      redirect = 1'b1; redirect_pc = redir_target;
      redir_on_resp = 1'b0; auto_fired = 1'b1; redir_done = 1'b1;
      redir_cyc = cyc; redir_idx = reqs.size();
    end

    resp = mem_valid && pend;
    if (rst) begin
      orphan = pend && !resp;
      q.delete();
      pend = 1'b0; live = 1'b0; exp_req = 1'b0;
      exp_addr = RESET_PC; held_addr = '0;
      m_fetched = 0; m_flushed = 0;
    end else begin
      keep   = resp && live && !redirect;
      do_pop = (q.size() != 0) && instr_ready && !redirect;
      if (do_pop) begin
        consumed.push_back(q[0]);
        cdata.push_back(instr_data);
        void'(q.pop_front());
      end
      if (keep) begin
        q.push_back(paddr);
        if (m_fetched < 65535) m_fetched++;
      end
      can_issue = !redirect && bus_grant && (!pend || (resp && live)) && (q.size() < DEPTH);
      if (resp) pend = 1'b0;
      if (redirect) begin
        q.delete();
        live = 1'b0;
        exp_addr = redirect_pc;
        if (m_flushed < 65535) m_flushed++;
      end
      exp_req = can_issue;
    end

    cyc++;
    @(posedge clk);
    #1;
    if (auto_fired) begin
      redirect = 1'b0;
      auto_fired = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h5A5A; bus_grant = 1'b1;
    mem_valid = 1'b0; mem_rdata = 8'h00; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (mem_req !== 1'b0)      begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    if (mem_addr !== 16'h0)    begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    if (instr_valid !== 1'b0)  begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    if (instr_data !== 8'h0)   begin errors++; $display("FAIL reset_instr_data: got %h expected 00", instr_data); end
    if (instr_pc !== 16'h0)    begin errors++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
    if (fetch_pc !== RESET_PC) begin errors++; $display("FAIL reset_fetch_pc: got %h expected %h", fetch_pc, RESET_PC); end
    q.delete(); pend = 1'b0; live = 1'b0; orphan = 1'b0; exp_req = 1'b0;
    exp_addr = RESET_PC; held_addr = '0;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int c0, n;
    do_reset();
    bus_grant = 1'b1; instr_ready = 1'b1; lat_min = 1; lat_max = 1; spur_pct = 0;
    c0 = consumed.size();
    n = 0;
    while (consumed.size() < c0 + 3 && n < 50) begin cycle(); n++; end
    checks++;
    if (consumed.size() < c0 + 3) begin
      errors++; $display("FAIL stream_timeout: got %0d bytes expected 3", consumed.size() - c0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (consumed[c0+i] !== 16'(i) || cdata[c0+i] !== 8'(i)) begin
          errors++;
          $display("FAIL stream_order: got %h/%h expected %h/%h", consumed[c0+i], cdata[c0+i], 16'(i), 8'(i));
        end
      end
    end
  endtask

  task automatic test_fill();
    int r0, c0, n;
    do_reset();
    bus_grant = 1'b1; instr_ready = 1'b0; lat_min = 1; lat_max = 1;
    r0 = reqs.size();
    repeat (20) cycle();
    checks++;
    if (reqs.size() - r0 != DEPTH) begin
      errors++; $display("FAIL fill_req_count: got %0d expected %0d", reqs.size() - r0, DEPTH);
    end
    instr_ready = 1'b1;
    c0 = consumed.size();
    n = 0;
    while ((consumed.size() < c0 + 4 || reqs.size() < r0 + 5) && n < 40) begin cycle(); n++; end
    checks++;
    if (consumed.size() < c0 + 4 || reqs.size() < r0 + 5) begin
      errors++; $display("FAIL fill_timeout: got %0d pops expected 4", consumed.size() - c0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (consumed[c0+i] !== 16'(i)) begin
          errors++; $display("FAIL fill_pop_order: got %h expected %h", consumed[c0+i], 16'(i));
        end
      end
      checks++;
      if (reqs[r0+4] !== 16'h0004) begin
        errors++; $display("FAIL fill_next_req: got %h expected 0004", reqs[r0+4]);
      end
    end
  endtask

  task automatic test_redirect_late();
    int r0, r1, c0, n;
    do_reset();
    bus_grant = 1'b1; instr_ready = 1'b1; lat_min = 1; lat_max = 1;
    slow_en = 1'b1; slow_addr = 16'h0005; slow_lat = 3;
    r0 = reqs.size();
    n = 0;
    while (reqs.size() < r0 + 6 && n < 50) begin cycle(); n++; end
    redirect = 1'b1; redirect_pc = 16'h1234;
    c0 = consumed.size(); r1 = reqs.size();
    cycle();
    redirect = 1'b0;
    n = 0;
    while (consumed.size() <= c0 && n < 50) begin cycle(); n++; end
    slow_en = 1'b0;
    checks++;
    if (consumed.size() <= c0 || reqs.size() <= r1) begin
      errors++; $display("FAIL late_timeout: got %0d pops expected 1", consumed.size() - c0);
    end else begin
      checks += 2;
      if (reqs[r1] !== 16'h1234) begin
        errors++; $display("FAIL late_req_addr: got %h expected 1234", reqs[r1]);
      end
      if (consumed[c0] !== 16'h1234) begin
        errors++; $display("FAIL late_first_pc: got %h expected 1234", consumed[c0]);
      end
    end
  endtask

  task automatic test_redirect_on_resp();
    int n;
    bus_grant = 1'b1; instr_ready = 1'b1; lat_min = 2; lat_max = 2;
    redir_target = 16'h0080; redir_done = 1'b0; redir_on_resp = 1'b1;
    n = 0;
    while (!redir_done && n < 50) begin cycle(); n++; end
    redir_on_resp = 1'b0;
    n = 0;
    while (reqs.size() <= redir_idx && n < 20) begin cycle(); n++; end
    checks++;
    if (!redir_done || reqs.size() <= redir_idx) begin
      errors++; $display("FAIL same_cycle_timeout: got no request expected one");
    end else begin
      checks += 2;
      if (reqs[redir_idx] !== 16'h0080) begin
        errors++; $display("FAIL same_cycle_addr: got %h expected 0080", reqs[redir_idx]);
      end
      if (req_cyc[redir_idx] - redir_cyc != 2) begin
        errors++; $display("FAIL same_cycle_delay: got %0d expected 2", req_cyc[redir_idx] - redir_cyc);
      end
    end
  endtask

  task automatic test_wrap();
    int r0, c0, n;
    bus_grant = 1'b0; instr_ready = 1'b1; lat_min = 1; lat_max = 3;
    repeat (6) cycle();
    r0 = reqs.size();
    repeat (10) cycle();
    checks++;
    if (reqs.size() != r0) begin
      errors++; $display("FAIL no_grant: got %0d requests expected 0", reqs.size() - r0);
    end
    bus_grant = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    c0 = consumed.size();
    cycle();
    redirect = 1'b0;
    n = 0;
    while (consumed.size() < c0 + 2 && n < 50) begin cycle(); n++; end
    checks++;
    if (consumed.size() < c0 + 2) begin
      errors++; $display("FAIL wrap_timeout: got %0d pops expected 2", consumed.size() - c0);
    end else begin
      checks++;
      if (consumed[c0] !== 16'hFFFF || consumed[c0+1] !== 16'h0000 ||
          cdata[c0] !== 8'h80 || cdata[c0+1] !== 8'h00) begin
        errors++;
        $display("FAIL wrap: got %h/%h,%h/%h expected ffff/80,0000/00",
                 consumed[c0], cdata[c0], consumed[c0+1], cdata[c0+1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0, n;
    bus_grant = 1'b1; instr_ready = 1'b1; lat_min = 3; lat_max = 3;
    n = 0;
    while (!pend && n < 20) begin cycle(); n++; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", instr_valid); end
    if (fetch_pc !== RESET_PC) begin errors++; $display("FAIL midreset_fetch_pc: got %h expected %h", fetch_pc, RESET_PC); end
    c0 = consumed.size();
    n = 0;
    while (consumed.size() <= c0 && n < 50) begin cycle(); n++; end
    checks++;
    if (consumed.size() <= c0) begin
      errors++; $display("FAIL midreset_timeout: got 0 pops expected 1");
    end else if (consumed[c0] !== RESET_PC) begin
      errors++; $display("FAIL midreset_first_pc: got %h expected %h", consumed[c0], RESET_PC);
    end
  endtask

  task automatic test_random();
    int c0;
    lat_min = 1; lat_max = 4; spur_pct = 10;
    c0 = consumed.size();
    for (int i = 0; i < 3000; i++) begin
      bus_grant   = ($urandom_range(99) < 80);
      instr_ready = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 4);
      redirect_pc = ($urandom_range(7) == 0) ? 16'hFFFE : 16'($urandom);
      rst         = ($urandom_range(999) < 5);
      cycle();
    end
    rst = 1'b0; redirect = 1'b0; spur_pct = 0;
    checks++;
    if (consumed.size() < c0 + 300) begin
      errors++; $display("FAIL random_progress: got %0d pops expected >= 300", consumed.size() - c0);
    end
  endtask

`ifdef JAVK_FETCH_PERF_EN
  task automatic test_perf();
    int r0, n;
    do_reset();
    bus_grant = 1'b0; instr_ready = 1'b1; lat_min = 1; lat_max = 1;
    repeat (2) cycle();
    redirect = 1'b1; redirect_pc = 16'h0100; cycle();
    redirect_pc = 16'h0200; cycle();
    redirect = 1'b0;
    r0 = reqs.size();
    bus_grant = 1'b1;
    n = 0;
    while (reqs.size() < r0 + 6 && n < 100) begin cycle(); n++; end
    bus_grant = 1'b0;
    repeat (8) cycle();
    checks++;
    if (perf_fetched !== 16'd6 || perf_flushed !== 16'd2) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d expected 6/2", perf_fetched, perf_flushed);
    end
    bus_grant = 1'b1;
    repeat (3) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++;
    if (perf_fetched !== 16'd0 || perf_flushed !== 16'd0) begin
      errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_fetched, perf_flushed);
    end
    repeat (10) cycle();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_late();
    test_redirect_on_resp();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef JAVK_FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
